rr_mux4_arbiter: RTL

- Round-robin arbiter and sequencer for a shared 4:1 data multiplexer.
- Four requesters each present a data word and a request; the block grants one at a time and drives the mux select.
- It forwards the selected word over a valid/ready handshake to a single consumer.
- A grant is held for a bounded burst, then priority rotates.

---
 rtl/arb_pkg.sv | 7 +
 rtl/mux4.sv | 13 +
 rtl/rr_pick4.sv | 15 +
 rtl/rr_mux4_arbiter.sv | 83 ++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and state encoding for the round-robin mux arbiter
package arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W = 2;
    localparam int MAX_BEATS_DEF = 4;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/mux4.sv
// mux4: 4:1 data multiplexer cell
module mux4 #(
    parameter int W = 8
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [1:0]   s,
    output logic [W-1:0] y
);
    assign y = s[1] ? (s[0] ? d3 : d2) : (s[0] ? d1 : d0);
endmodule

// File: rtl/rr_pick4.sv
// rr_pick4: first set request bit searching upward from ptr, wrapping mod 4
module rr_pick4 import arb_pkg::*; (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);
    always_comb begin
        any = |req;
        idx = ptr;
        // walk from furthest to nearest so the closest match to ptr wins
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[ptr + SEL_W'(k)]) idx = ptr + SEL_W'(k);
    end
endmodule

// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter: round-robin burst arbiter driving a shared 4:1 mux onto a valid/ready output
module rr_mux4_arbiter import arb_pkg::*; #(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = MAX_BEATS_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] din,
    output logic [NUM_REQ-1:0]        in_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic [SEL_W-1:0]          sel,
    output logic [DATA_W-1:0]         dout,
    output logic                      out_valid,
    input  logic                      out_ready
);
    state_t state, state_nx;
    logic [SEL_W-1:0] sel_nx, ptr, ptr_nx, idx;
    logic [NUM_REQ-1:0] grant_nx;
    logic [3:0] beat_cnt, beat_nx;
    logic any, xfer, last;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .any (any),
        .idx (idx)
    );

    mux4 #(.W(DATA_W)) u_mux (
        .d0 (din[0*DATA_W +: DATA_W]),
        .d1 (din[1*DATA_W +: DATA_W]),
        .d2 (din[2*DATA_W +: DATA_W]),
        .d3 (din[3*DATA_W +: DATA_W]),
        .s  (sel),
        .y  (dout)
    );

    assign out_valid = (state == BUSY) & req[sel];
    assign xfer      = out_valid & out_ready;
    assign last      = beat_cnt == 4'(MAX_BEATS - 1);
    assign in_ready  = grant & {NUM_REQ{out_ready}};

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        ptr_nx   = ptr;
        grant_nx = grant;
        beat_nx  = beat_cnt;
        if (state == IDLE) begin
            if (any) begin
                state_nx = BUSY;
                sel_nx   = idx;
                grant_nx = NUM_REQ'(1) << idx;
                beat_nx  = '0;
            end
        end else if (!req[sel] || (xfer && last)) begin
            // release always passes through IDLE and demotes the current grantee
            state_nx = IDLE;
            grant_nx = '0;
            beat_nx  = '0;
            ptr_nx   = sel + 1'b1;
        end else if (xfer) begin
            beat_nx = beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            ptr      <= '0;
            grant    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            sel      <= sel_nx;
            ptr      <= ptr_nx;
            grant    <= grant_nx;
            beat_cnt <= beat_nx;
        end
    end
endmodule
